fc_tx_credit_gate: RTL and testbench

Transmit-side flow-control credit gate for one PCIe TL credit class (header + data pair, e.g. Posted). It is the far-end counterpart of the receiver credit buffer. It learns the receiver's advertised credit limits from InitFC/UpdateFC information, tracks credits consumed by transmitted TLPs, and grants a TLP only when both header and data credits are sufficient. It sits between the TL transmit arbiter and the DLL-facing TLP output.

---
 rtl/fc_tx_credit_gate.sv | 166 ++++++++++++++++
 tb/tb_fc_tx_credit_gate.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fc_tx_credit_gate.sv
// Transmit-side PCIe flow-control credit gate for one header+data credit class.
// Latency: grant registered, 1 cycle after a qualifying request; avail outputs 1 cycle after update/grant.
// Backpressure: tx_req is held until tx_gnt; grants are spaced at least 2 cycles apart.
// Optional stall watchdog is compiled in with `define FC_TX_WDOG_EN.
module fc_tx_credit_gate #(
    parameter int HDR_W          = 8,
    parameter int DATA_W         = 12,
    parameter int LEN_W          = 10,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              link_up,
    input  logic              fc_init_valid,
    input  logic [HDR_W-1:0]  fc_init_hdr,
    input  logic [DATA_W-1:0] fc_init_data,
    input  logic              fc_upd_valid,
    input  logic [HDR_W-1:0]  fc_upd_hdr,
    input  logic [DATA_W-1:0] fc_upd_data,
    input  logic              tx_req,
    input  logic [LEN_W-1:0]  tx_data_cr,
    output logic              tx_gnt,
    output logic              fc_ready,
    output logic [HDR_W-1:0]  hdr_avail,
    output logic [DATA_W-1:0] data_avail,
    output logic              fc_stall
);

    typedef enum logic [1:0] {S_IDLE, S_INIT, S_ACTIVE} state_t;

    // Half of each modulo space: a remaining-credit difference above this means "negative".
    localparam logic [HDR_W-1:0]  HALF_H = {1'b1, {(HDR_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] HALF_D = {1'b1, {(DATA_W-1){1'b0}}};

    state_t             state, state_n;
    logic [HDR_W-1:0]   hdr_lim, hdr_cons, hdr_lim_n, hdr_cons_n;
    logic [DATA_W-1:0]  data_lim, data_cons, data_lim_n, data_cons_n;
    logic               inf_h, inf_d, inf_h_n, inf_d_n;
    logic [HDR_W-1:0]   hdr_room;
    logic [DATA_W-1:0]  data_req, data_room;
    logic               hdr_ok, data_ok, grant_n;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    // Next-state: link loss wins from any state
    always_comb begin
        state_n = state;
        if (!link_up) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   state_n = S_INIT;
                S_INIT:   if (fc_init_valid) state_n = S_ACTIVE;
                S_ACTIVE: state_n = S_ACTIVE;
                default:  state_n = S_IDLE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        fc_ready = (state == S_ACTIVE);
    end

    // Credit check: the modulo difference must not have gone "negative" after this TLP
    always_comb begin
        data_req  = DATA_W'(tx_data_cr);
        hdr_room  = hdr_lim - hdr_cons - HDR_W'(1);
        data_room = data_lim - data_cons - data_req;
        hdr_ok    = inf_h || (hdr_room <= HALF_H);
        data_ok   = inf_d || (tx_data_cr == '0) || (data_room <= HALF_D);
        // A cycle already showing tx_gnt is the handshake cycle, not a new request.
        grant_n   = (state == S_ACTIVE) && link_up && tx_req && !tx_gnt && hdr_ok && data_ok;
    end

    // Next values of limits, consumed counters and infinite flags
    always_comb begin
        hdr_lim_n   = hdr_lim;
        hdr_cons_n  = hdr_cons;
        data_lim_n  = data_lim;
        data_cons_n = data_cons;
        inf_h_n     = inf_h;
        inf_d_n     = inf_d;
        if (state == S_IDLE && state_n == S_INIT) begin
            hdr_lim_n   = '0;
            hdr_cons_n  = '0;
            data_lim_n  = '0;
            data_cons_n = '0;
            inf_h_n     = 1'b0;
            inf_d_n     = 1'b0;
        end else if (state == S_INIT && state_n == S_ACTIVE) begin
            hdr_lim_n  = fc_init_hdr;
            data_lim_n = fc_init_data;
            inf_h_n    = (fc_init_hdr == '0);
            inf_d_n    = (fc_init_data == '0);
        end else if (state == S_ACTIVE) begin
            // Grant was checked against the old limits; both fields move at this edge.
            if (fc_upd_valid && !inf_h) hdr_lim_n  = fc_upd_hdr;
            if (fc_upd_valid && !inf_d) data_lim_n = fc_upd_data;
            if (grant_n && !inf_h)      hdr_cons_n  = hdr_cons + HDR_W'(1);
            if (grant_n && !inf_d)      data_cons_n = data_cons + data_req;
        end
    end

    // Credit state, grant and availability registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_lim    <= '0;
            hdr_cons   <= '0;
            data_lim   <= '0;
            data_cons  <= '0;
            inf_h      <= 1'b0;
            inf_d      <= 1'b0;
            tx_gnt     <= 1'b0;
            hdr_avail  <= '0;
            data_avail <= '0;
        end else begin
            hdr_lim    <= hdr_lim_n;
            hdr_cons   <= hdr_cons_n;
            data_lim   <= data_lim_n;
            data_cons  <= data_cons_n;
            inf_h      <= inf_h_n;
            inf_d      <= inf_d_n;
            tx_gnt     <= grant_n;
            hdr_avail  <= inf_h_n ? '1 : (hdr_lim_n - hdr_cons_n);
            data_avail <= inf_d_n ? '1 : (data_lim_n - data_cons_n);
        end
    end

`ifdef FC_TX_WDOG_EN
    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] wd_cnt, wd_cnt_n;
    logic             stall_q;

    // Count blocked request cycles; any credit movement restarts the count
    always_comb begin
        wd_cnt_n = wd_cnt;
        if (state != S_ACTIVE || state_n != S_ACTIVE)  wd_cnt_n = '0;
        else if (grant_n || fc_upd_valid)              wd_cnt_n = '0;
        else if (tx_req && wd_cnt != WD_LIMIT)         wd_cnt_n = wd_cnt + CNT_W'(1);
    end

    // Stall flag is sticky while ACTIVE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt  <= '0;
            stall_q <= 1'b0;
        end else begin
            wd_cnt <= wd_cnt_n;
            if (state != S_ACTIVE || state_n != S_ACTIVE) stall_q <= 1'b0;
            else if (wd_cnt_n == WD_LIMIT)                stall_q <= 1'b1;
        end
    end

    assign fc_stall = stall_q;
`else
    assign fc_stall = 1'b0;
`endif

endmodule

// File: tb/tb_fc_tx_credit_gate.sv
// Directed bench for fc_tx_credit_gate: vector table plus wrap, infinite and stall sequences.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
// Prints one summary line with check and error counts.
module tb_fc_tx_credit_gate;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        link_up;
    logic        fc_init_valid;
    logic [7:0]  fc_init_hdr;
    logic [11:0] fc_init_data;
    logic        fc_upd_valid;
    logic [7:0]  fc_upd_hdr;
    logic [11:0] fc_upd_data;
    logic        tx_req;
    logic [9:0]  tx_data_cr;
    logic        tx_gnt;
    logic        fc_ready;
    logic [7:0]  hdr_avail;
    logic [11:0] data_avail;
    logic        fc_stall;

    int checks = 0;
    int errors = 0;

    fc_tx_credit_gate #(
        .HDR_W(8), .DATA_W(12), .LEN_W(10), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .link_up(link_up),
        .fc_init_valid(fc_init_valid), .fc_init_hdr(fc_init_hdr), .fc_init_data(fc_init_data),
        .fc_upd_valid(fc_upd_valid), .fc_upd_hdr(fc_upd_hdr), .fc_upd_data(fc_upd_data),
        .tx_req(tx_req), .tx_data_cr(tx_data_cr), .tx_gnt(tx_gnt), .fc_ready(fc_ready),
        .hdr_avail(hdr_avail), .data_avail(data_avail), .fc_stall(fc_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        link;
        logic        ivld;
        logic [7:0]  ih;
        logic [11:0] id;
        logic        uvld;
        logic [7:0]  uh;
        logic [11:0] ud;
        logic        req;
        logic [9:0]  cr;
        logic        e_gnt;
        logic        e_rdy;
        logic [7:0]  e_h;
        logic [11:0] e_d;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic link, input logic ivld, input int ih, input int id,
                                input logic uvld, input int uh, input int ud,
                                input logic req, input int cr,
                                input logic eg, input logic er, input int eh, input int ed);
        vec_t v;
        v.link = link; v.ivld = ivld; v.ih = 8'(ih); v.id = 12'(id);
        v.uvld = uvld; v.uh = 8'(uh); v.ud = 12'(ud);
        v.req = req; v.cr = 10'(cr);
        v.e_gnt = eg; v.e_rdy = er; v.e_h = 8'(eh); v.e_d = 12'(ed);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 8; c++) begin
            cyc();
            if (tx_gnt) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic relink(input int ih, input int id);
        link_up = 1'b0; tx_req = 1'b0; fc_upd_valid = 1'b0;
        cyc();
        link_up = 1'b1;
        cyc();
        fc_init_valid = 1'b1; fc_init_hdr = 8'(ih); fc_init_data = 12'(id);
        cyc();
        fc_init_valid = 1'b0;
    endtask

    initial begin
        bit ok;
        int cons, ngnt, gcount, consec;
        logic prev;

        // Columns: link ivld ih id | uvld uh ud | req cr | gnt rdy havail davail
        vecs[0]  = mk(0,0,0,0,       0,0,0,      0,0,     0,0,0,0);
        vecs[1]  = mk(1,1,7,7,       0,0,0,      0,0,     0,0,0,0);
        vecs[2]  = mk(1,1,4,16,      0,0,0,      0,0,     0,1,4,16);
        vecs[3]  = mk(1,0,0,0,       0,0,0,      1,4,     1,1,3,12);
        vecs[4]  = mk(1,0,0,0,       0,0,0,      1,4,     0,1,3,12);
        vecs[5]  = mk(1,0,0,0,       0,0,0,      1,4,     1,1,2,8);
        vecs[6]  = mk(1,0,0,0,       0,0,0,      1,4,     0,1,2,8);
        vecs[7]  = mk(1,0,0,0,       0,0,0,      1,4,     1,1,1,4);
        vecs[8]  = mk(1,0,0,0,       0,0,0,      1,4,     0,1,1,4);
        vecs[9]  = mk(1,0,0,0,       0,0,0,      1,4,     1,1,0,0);
        vecs[10] = mk(1,0,0,0,       0,0,0,      1,4,     0,1,0,0);
        vecs[11] = mk(1,0,0,0,       0,0,0,      1,4,     0,1,0,0);
        vecs[12] = mk(1,0,0,0,       1,6,24,     1,4,     0,1,2,8);
        vecs[13] = mk(1,0,0,0,       0,0,0,      1,4,     1,1,1,4);
        vecs[14] = mk(1,0,0,0,       0,0,0,      0,0,     0,1,1,4);
        vecs[15] = mk(1,0,0,0,       1,10,24,    0,0,     0,1,5,4);
        vecs[16] = mk(1,0,0,0,       0,0,0,      1,5,     0,1,5,4);
        vecs[17] = mk(1,0,0,0,       0,0,0,      1,4,     1,1,4,0);
        vecs[18] = mk(1,0,0,0,       0,0,0,      1,0,     0,1,4,0);
        vecs[19] = mk(1,0,0,0,       0,0,0,      1,0,     1,1,3,0);
        vecs[20] = mk(0,0,0,0,       0,0,0,      1,0,     0,0,3,0);
        vecs[21] = mk(1,0,0,0,       0,0,0,      0,0,     0,0,0,0);
        vecs[22] = mk(1,1,5,0,       0,0,0,      0,0,     0,1,5,12'hFFF);
        vecs[23] = mk(1,0,0,0,       0,0,0,      1,10'h3FF,1,1,4,12'hFFF);
        vecs[24] = mk(1,0,0,0,       1,9,16,     1,10'h3FF,0,1,8,12'hFFF);
        vecs[25] = mk(1,1,1,1,       0,0,0,      1,10'h3FF,1,1,7,12'hFFF);

        rst_n = 1'b0; link_up = 1'b0; fc_init_valid = 1'b0; fc_init_hdr = '0; fc_init_data = '0;
        fc_upd_valid = 1'b0; fc_upd_hdr = '0; fc_upd_data = '0; tx_req = 1'b0; tx_data_cr = '0;
        repeat (3) cyc();
        chk("rst_gnt",   int'(tx_gnt),     0);
        chk("rst_ready", int'(fc_ready),   0);
        chk("rst_havail",int'(hdr_avail),  0);
        chk("rst_davail",int'(data_avail), 0);
        chk("rst_stall", int'(fc_stall),   0);
        rst_n = 1'b1;
        cyc();

        // Table-driven single-cycle vectors
        for (int i = 0; i < NV; i++) begin
            link_up = vecs[i].link; fc_init_valid = vecs[i].ivld;
            fc_init_hdr = vecs[i].ih; fc_init_data = vecs[i].id;
            fc_upd_valid = vecs[i].uvld; fc_upd_hdr = vecs[i].uh; fc_upd_data = vecs[i].ud;
            tx_req = vecs[i].req; tx_data_cr = vecs[i].cr;
            cyc();
            chk($sformatf("v%0d_gnt", i),    int'(tx_gnt),     int'(vecs[i].e_gnt));
            chk($sformatf("v%0d_ready", i),  int'(fc_ready),   int'(vecs[i].e_rdy));
            chk($sformatf("v%0d_havail", i), int'(hdr_avail),  int'(vecs[i].e_h));
            chk($sformatf("v%0d_davail", i), int'(data_avail), int'(vecs[i].e_d));
        end
        fc_init_valid = 1'b0; fc_upd_valid = 1'b0; tx_req = 1'b0;

        // Header counter wrap: walk consumed up to 0xFE with rolling limit updates
        relink(100, 16);
        tx_data_cr = '0;
        cons = 0; ngnt = 0;
        for (int k = 0; k < 254; k++) begin
            fc_upd_valid = 1'b1; fc_upd_hdr = 8'((cons + 64) % 256); fc_upd_data = 12'd16;
            cyc();
            fc_upd_valid = 1'b0; tx_req = 1'b1;
            wait_gnt(ok);
            tx_req = 1'b0;
            if (ok) ngnt++;
            cons = (cons + 1) % 256;
        end
        chk("wrap_walk_grants", ngnt, 254);
        fc_upd_valid = 1'b1; fc_upd_hdr = 8'h02;
        cyc();
        fc_upd_valid = 1'b0;
        chk("wrap_avail4", int'(hdr_avail), 4);
        tx_req = 1'b1; wait_gnt(ok); tx_req = 1'b0;
        chk("wrap_gnt1", int'(ok), 1);
        chk("wrap_avail3", int'(hdr_avail), 3);
        cyc();
        tx_req = 1'b1; wait_gnt(ok); tx_req = 1'b0;
        chk("wrap_gnt2", int'(ok), 1);
        chk("wrap_avail2", int'(hdr_avail), 2);
        chk("wrap_davail", int'(data_avail), 16);

        // Infinite credits: continuous requests granted every other cycle
        relink(0, 0);
        tx_req = 1'b1; tx_data_cr = 10'd7;
        gcount = 0; consec = 0; prev = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            cyc();
            if (tx_gnt) gcount++;
            if (tx_gnt && prev) consec++;
            prev = tx_gnt;
        end
        tx_req = 1'b0;
        chk("inf_grants", gcount, 1000);
        chk("inf_consecutive", consec, 0);
        chk("inf_havail", int'(hdr_avail), 32'hFF);
        chk("inf_davail", int'(data_avail), 32'hFFF);
        fc_upd_valid = 1'b1; fc_upd_hdr = 8'd3; fc_upd_data = 12'd3;
        cyc();
        fc_upd_valid = 1'b0;
        cyc();
        chk("inf_upd_havail", int'(hdr_avail), 32'hFF);
        chk("inf_upd_davail", int'(data_avail), 32'hFFF);

        // Blocked request: stall watchdog behaviour, then link drop
        relink(1, 16);
        tx_req = 1'b1; tx_data_cr = '0;
        wait_gnt(ok);
        chk("stall_first_gnt", int'(ok), 1);
        repeat (3) cyc();
        chk("stall_early", int'(fc_stall), 0);
        repeat (10) cyc();
`ifdef FC_TX_WDOG_EN
        chk("stall_fired", int'(fc_stall), 1);
`else
        chk("stall_tied_low", int'(fc_stall), 0);
`endif
        chk("stall_no_gnt", int'(tx_gnt), 0);
        link_up = 1'b0;
        cyc();
        tx_req = 1'b0;
        chk("drop_stall", int'(fc_stall), 0);
        chk("drop_ready", int'(fc_ready), 0);
        chk("drop_gnt", int'(tx_gnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
